// File: rtl/mcp_frame_assembler.sv
// mcp_frame_assembler
//   Front end of the MCP response decoder. Hunts the UART byte stream for
//   START_BYTE, gathers a 12-byte frame (start, 2B header, 7B payload,
//   error byte, end byte), validates it and presents it as a 96-bit word
//   with a level-held receive flag.
//
//   Build option: define MCP_CHECKSUM_EN to also require the error byte to
//   equal the XOR of the 9 header+payload bytes.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   iByte       received byte
//   iByteValid  one-cycle strobe qualifying iByte
//   iAck        consumer has taken oMsg; clears oRxFlag and oOverrun
//   oMsg        last valid frame, first byte in [95:88], last in [7:0]
//   oRxFlag     high while oMsg holds an unacknowledged frame
//   oFrameErr   one-cycle pulse per discarded frame
//   oOverrun    sticky: a valid frame replaced an unacknowledged one
module mcp_frame_assembler #(
  parameter logic [7:0] START_BYTE     = 8'h0F,
  parameter logic [7:0] END_BYTE       = 8'hF0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  iByte,
  input  logic        iByteValid,
  input  logic        iAck,
  output logic [95:0] oMsg,
  output logic        oRxFlag,
  output logic        oFrameErr,
  output logic        oOverrun
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t        state;
  logic [3:0]    byteCount;
  logic [TW-1:0] idleCount;
  logic [87:0]   shiftBuf;   // first 11 bytes of the frame, newest in [7:0]

  // Full frame as it looks in the cycle the 12th byte arrives.
  logic [95:0] frame;
  logic        endOk;
  logic        frameOk;

  assign frame = {shiftBuf, iByte};
  assign endOk = (iByte == END_BYTE);

`ifdef MCP_CHECKSUM_EN
  logic [7:0] bodyXor;

  // Bytes 1..9 of the frame are header and payload.
  always_comb begin
    bodyXor = 8'h00;
    for (int i = 1; i <= 9; i++) begin
      bodyXor = bodyXor ^ frame[95 - 8*i -: 8];
    end
  end

  assign frameOk = endOk && (frame[15:8] == bodyXor);
`else
  assign frameOk = endOk;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      byteCount <= 4'd0;
      idleCount <= '0;
      shiftBuf  <= 88'd0;
      oMsg      <= 96'd0;
      oRxFlag   <= 1'b0;
      oFrameErr <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      oFrameErr <= 1'b0;

      // Acknowledge first; a completing frame below overrides the flag.
      if (iAck) begin
        oRxFlag  <= 1'b0;
        oOverrun <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (iByteValid && (iByte == START_BYTE)) begin
            shiftBuf  <= {80'd0, iByte};
            byteCount <= 4'd1;
            idleCount <= '0;
            state     <= COLLECT;
          end
        end

        COLLECT: begin
          if (iByteValid) begin
            // An arriving byte always beats a pending timeout.
            idleCount <= '0;
            if (byteCount == 4'd11) begin
              state     <= HUNT;
              byteCount <= 4'd0;
              if (frameOk) begin
                oMsg    <= frame;
                oRxFlag <= 1'b1;
                if (oRxFlag && !iAck) begin
                  oOverrun <= 1'b1;
                end
              end else begin
                oFrameErr <= 1'b1;
              end
            end else begin
              shiftBuf  <= {shiftBuf[79:0], iByte};
              byteCount <= byteCount + 4'd1;
            end
          end else if (idleCount == IDLE_LAST) begin
            oFrameErr <= 1'b1;
            state     <= HUNT;
            byteCount <= 4'd0;
            idleCount <= '0;
          end else begin
            // Stops at IDLE_LAST, so the counter can never wrap.
            idleCount <= idleCount + 1'b1;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_frame_assembler.sv
// Testbench for mcp_frame_assembler: directed scenarios plus randomized
// frames, checked through an event scoreboard against a frame-level model.
module tb_mcp_frame_assembler;

  localparam int TIMEOUT = 1024;
`ifdef MCP_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  iByte = 8'h00;
  logic        iByteValid = 1'b0;
  logic        iAck = 1'b0;
  logic [95:0] oMsg;
  logic        oRxFlag;
  logic        oFrameErr;
  logic        oOverrun;

  mcp_frame_assembler #(
    .START_BYTE(8'h0F),
    .END_BYTE(8'hF0),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iByte(iByte),
    .iByteValid(iByteValid),
    .iAck(iAck),
    .oMsg(oMsg),
    .oRxFlag(oRxFlag),
    .oFrameErr(oFrameErr),
    .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        isErr;
    logic [95:0] msg;
  } evt_t;

  evt_t        expQ[$];
  int          checks = 0;
  int          errors = 0;

  // Frame-level model state.
  logic        flagExp = 1'b0;
  logic        overrunExp = 1'b0;
  logic [95:0] lastMsgExp = 96'd0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [95:0] buildFrame(input logic [15:0] hdr, input logic [55:0] pay,
                                             input logic [7:0] sumFlip, input logic [7:0] endB);
    logic [71:0] body;
    logic [7:0]  s;
    body = {hdr, pay};
    s = 8'h00;
    for (int i = 0; i < 9; i++) s = s ^ body[8*i +: 8];
    return {8'h0F, body, s ^ sumFlip, endB};
  endfunction

  function automatic bit frameValid(input logic [95:0] f);
    logic [7:0] s;
    bit sumOk;
    s = 8'h00;
    for (int i = 0; i < 9; i++) s = s ^ f[16 + 8*i +: 8];
    sumOk = (f[15:8] == s);
    return (f[7:0] == 8'hF0) && (sumOk || !CHK_EN);
  endfunction

  // ---------------- monitor ----------------
  logic        prevFlag = 1'b0;
  logic [95:0] prevMsg = 96'd0;
  evt_t        monEvt;

  always @(negedge clk) begin
    if (reset) begin
      if (oFrameErr) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected frameErr: got pulse expected none");
        end else begin
          monEvt = expQ.pop_front();
          checkBit("event kind (err)", 1'b1, monEvt.isErr);
          $display("event: frame error");
        end
      end
      if (oRxFlag && (!prevFlag || oMsg !== prevMsg)) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected frame: got %h expected none", oMsg);
        end else begin
          monEvt = expQ.pop_front();
          checkBit("event kind (frame)", 1'b0, monEvt.isErr);
          check("frame msg", oMsg, monEvt.msg);
          $display("event: frame %h", oMsg);
        end
      end
    end
    prevFlag = oRxFlag;
    prevMsg  = oMsg;
  end

  // ---------------- stimulus helpers ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic sendBytes(input logic [95:0] f, input int n, input int gap, input bit ackLast);
    for (int k = 0; k < n; k++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin @(posedge clk); #1; end
      iByte = f[95 - 8*k -: 8];
      iByteValid = 1'b1;
      iAck = ackLast && (k == n - 1);
      @(posedge clk); #1;
      iByteValid = 1'b0;
      iAck = 1'b0;
    end
  endtask

  task automatic sendFrame(input logic [95:0] f, input int gap, input bit ackLast);
    evt_t e;
    if (frameValid(f)) begin
      e.isErr = 1'b0;
      e.msg = f;
      overrunExp = (flagExp && !ackLast) ? 1'b1 : (ackLast ? 1'b0 : overrunExp);
      flagExp = 1'b1;
      lastMsgExp = f;
    end else begin
      e.isErr = 1'b1;
      e.msg = 96'd0;
      if (ackLast) begin flagExp = 1'b0; overrunExp = 1'b0; end
    end
    expQ.push_back(e);
    sendBytes(f, 12, gap, ackLast);
    // One clock after the end-byte strobe.
    checkBit("rxFlag after frame", oRxFlag, flagExp);
    checkBit("overrun after frame", oOverrun, overrunExp);
    check("msg after frame", oMsg, lastMsgExp);
  endtask

  task automatic doAck();
    iAck = 1'b1;
    @(posedge clk); #1;
    iAck = 1'b0;
    flagExp = 1'b0;
    overrunExp = 1'b0;
    checkBit("rxFlag after ack", oRxFlag, 1'b0);
    checkBit("overrun after ack", oOverrun, 1'b0);
    check("msg held after ack", oMsg, lastMsgExp);
  endtask

  task automatic drainWait(input string name, input int limit, output int n);
    n = 0;
    while (expQ.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: got %0d pending events expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [95:0] f;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check("reset msg", oMsg, 96'd0);
    checkBit("reset rxFlag", oRxFlag, 1'b0);
    checkBit("reset frameErr", oFrameErr, 1'b0);
    checkBit("reset overrun", oOverrun, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed frame, one byte per 4 clocks.
    f = buildFrame(16'hFFF2, 56'hDEADBEEF000000, 8'h00, 8'hF0);
    sendFrame(f, 3, 1'b0);
    check("header field", 96'(oMsg[87:72]), 96'h0000_FFF2);
    check("payload field", 96'(oMsg[71:40]), 96'hDEAD_BEEF);
    doAck();

    // Garbage before a valid frame is dropped without error.
    sendBytes(96'h55AA_0000_0000_0000_0000_0000, 2, 1, 1'b0);
    f = buildFrame(16'h1234, 56'h01020304050607, 8'h00, 8'hF0);
    sendFrame(f, -1, 1'b0);
    doAck();

    // Bad end byte.
    f = buildFrame(16'hABCD, 56'h11223344556677, 8'h00, 8'hEE);
    sendFrame(f, -1, 1'b0);

    // Partial frame then silence: timeout.
    expQ.push_back('{isErr: 1'b1, msg: 96'd0});
    sendBytes(buildFrame(16'h5555, 56'h0, 8'h00, 8'hF0), 5, 1, 1'b0);
    drainWait("timeout event", TIMEOUT + 50, n);
    checks++;
    if (n < TIMEOUT || n > TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout latency: got %0d clocks expected %0d..%0d", n, TIMEOUT, TIMEOUT + 1);
    end
    f = buildFrame(16'h0F0F, 56'hCAFEF00D0F0F0F, 8'h00, 8'hF0);
    sendFrame(f, -1, 1'b0);

    // Second frame without ack: overrun.
    f = buildFrame(16'h2222, 56'h33333333333333, 8'h00, 8'hF0);
    sendFrame(f, -1, 1'b0);
    doAck();

    // Error byte off by one bit.
    f = buildFrame(16'h4444, 56'h00112233445566, 8'h01, 8'hF0);
    sendFrame(f, -1, 1'b0);
    if (flagExp) doAck();

    // Ack coinciding with a valid completion while the flag is set.
    f = buildFrame(16'h6666, 56'h77777777777777, 8'h00, 8'hF0);
    sendFrame(f, -1, 1'b0);
    f = buildFrame(16'h8888, 56'h99999999999999, 8'h00, 8'hF0);
    sendFrame(f, -1, 1'b1);

    // Reset after byte 6 of a frame.
    sendBytes(buildFrame(16'hAAAA, 56'hBBBBBBBBBBBBBB, 8'h00, 8'hF0), 6, 1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("mid-reset msg", oMsg, 96'd0);
    checkBit("mid-reset rxFlag", oRxFlag, 1'b0);
    checkBit("mid-reset frameErr", oFrameErr, 1'b0);
    checkBit("mid-reset overrun", oOverrun, 1'b0);
    flagExp = 1'b0; overrunExp = 1'b0; lastMsgExp = 96'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    f = buildFrame(16'hC0DE, 56'h0123456789ABCD, 8'h00, 8'hF0);
    sendFrame(f, -1, 1'b0);
    doAck();

    // Randomized frames.
    for (int it = 0; it < 30; it++) begin
      logic [15:0] hdr;
      logic [55:0] pay;
      logic [7:0]  flip;
      logic [7:0]  endB;
      int r;
      hdr = 16'($urandom);
      pay = {8'(8'h80 + it), 16'($urandom), 32'($urandom)};
      flip = 8'h00;
      endB = 8'hF0;
      r = int'($urandom_range(0, 5));
      if (r == 0) endB = 8'hF0 ^ 8'($urandom_range(1, 255));
      if (r == 1) flip = 8'(1 << $urandom_range(0, 7));
      sendFrame(buildFrame(hdr, pay, flip, endB), -1, 1'($urandom_range(0, 3) == 0));
      if (flagExp && $urandom_range(0, 1) == 1) doAck();
    end

    drainWait("final drain", 20, n);
    repeat (2) @(posedge clk);
    check("queue drained", 96'(expQ.size()), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
